// File: rtl/operand_stack_pkg.sv
// Shared types for the operand stack: command opcodes and field widths.
package operand_stack_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    NOP   = 3'd0,
    PUSH  = 3'd1,
    POP1  = 3'd2,
    POP2  = 3'd3,
    PEEK  = 3'd4,
    CLEAR = 3'd5
  } stack_cmd_e;

endpackage

// File: rtl/operand_stack_mem.sv
// Operand storage: one synchronous write port, two combinational read ports.
// The array is deliberately not reset; the stack count defines which entries are live.
module operand_stack_mem #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 10,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/operand_stack.sv
// Operand stack with a valid/ready command port and a held two-operand response.
// Define OPERAND_STACK_ERR_EN to add sticky overflow/underflow flags with a clear input.
module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [CMD_W-1:0]           cmd,
  input  logic signed [WIDTH-1:0]    d,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic signed [WIDTH-1:0]    q1,
  output logic signed [WIDTH-1:0]    q2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
`ifdef OPERAND_STACK_ERR_EN
  ,
  output logic                       err_ovf,
  output logic                       err_udf,
  input  logic                       err_clr
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  stack_cmd_e       op;
  logic             accept;
  logic             has1;
  logic             has2;
  logic             push_ok;
  logic [AW-1:0]    top_addr;
  logic [AW-1:0]    next_addr;
  logic [WIDTH-1:0] top_data;
  logic [WIDTH-1:0] next_data;

  assign op        = stack_cmd_e'(cmd);
  assign cmd_ready = !rsp_valid || rsp_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign has1      = (count != '0);
  assign has2      = (count > CW'(1));
  assign push_ok   = accept && (op == PUSH) && !full;

  // Read addresses are parked at 0 when absent so the array is never indexed out of range.
  assign top_addr  = has1 ? AW'(count - CW'(1)) : '0;
  assign next_addr = has2 ? AW'(count - CW'(2)) : '0;

  operand_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we      (push_ok),
    .waddr   (AW'(count)),
    .wdata   (d),
    .raddr_a (top_addr),
    .raddr_b (next_addr),
    .rdata_a (top_data),
    .rdata_b (next_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      rsp_valid <= 1'b0;
      q1        <= '0;
      q2        <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      if (accept) begin
        case (op)
          PUSH: begin
            if (!full) count <= count + CW'(1);
          end
          POP1: begin
            rsp_valid <= 1'b1;
            q1        <= has1 ? top_data : '0;
            q2        <= '0;
            if (has1) count <= count - CW'(1);
          end
          POP2: begin
            rsp_valid <= 1'b1;
            q1        <= has1 ? top_data : '0;
            q2        <= has2 ? next_data : '0;
            count     <= has2 ? count - CW'(2) : '0;
          end
          PEEK: begin
            rsp_valid <= 1'b1;
            q1        <= has1 ? top_data : '0;
            q2        <= has2 ? next_data : '0;
          end
          CLEAR: begin
            count <= '0;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef OPERAND_STACK_ERR_EN
  logic ovf_evt;
  logic udf_evt;

  assign ovf_evt = accept && (op == PUSH) && full;
  assign udf_evt = accept && ((op == POP1) || (op == POP2)) && !has1;

  // A new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (ovf_evt)      err_ovf <= 1'b1;
      else if (err_clr) err_ovf <= 1'b0;
      if (udf_evt)      err_udf <= 1'b1;
      else if (err_clr) err_udf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: directed scenarios followed by random traffic,
// all checked against a queue-based stack model. Error-flag checks follow OPERAND_STACK_ERR_EN.
module tb_operand_stack;
  import operand_stack_pkg::*;

  localparam int WIDTH = 36;
  localparam int DEPTH = 10;
  localparam int CW    = $clog2(DEPTH+1);

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [CMD_W-1:0]        cmd = '0;
  logic signed [WIDTH-1:0] d = '0;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b0;
  logic signed [WIDTH-1:0] q1;
  logic signed [WIDTH-1:0] q2;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    err_clr = 1'b0;
`ifdef OPERAND_STACK_ERR_EN
  logic                    err_ovf;
  logic                    err_udf;
`endif

  operand_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .d         (d),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .q1        (q1),
    .q2        (q2),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef OPERAND_STACK_ERR_EN
    ,
    .err_ovf   (err_ovf),
    .err_udf   (err_udf),
    .err_clr   (err_clr)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue whose back is the top of stack.
  logic signed [WIDTH-1:0] stk [$];
  bit                      m_rv;
  bit                      m_qchk;
  bit                      m_eo;
  bit                      m_eu;
  logic signed [WIDTH-1:0] m_q1;
  logic signed [WIDTH-1:0] m_q2;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic signed [WIDTH-1:0] sv(input int x);
    return WIDTH'(x);
  endfunction

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic modelStep(input bit rst, input bit v, input logic [CMD_W-1:0] c,
                           input logic signed [WIDTH-1:0] dd, input bit rr, input bit ec);
    bit acc, ovf, udf;
    if (rst) begin
      stk.delete();
      m_rv = 0; m_qchk = 1; m_eo = 0; m_eu = 0;
      m_q1 = '0; m_q2 = '0;
      return;
    end
    acc = v && (!m_rv || rr);
    ovf = 0;
    udf = 0;
    if (m_rv && rr) m_rv = 0;
    if (acc) begin
      case (c)
        PUSH: begin
          if (stk.size() < DEPTH) stk.push_back(dd);
          else ovf = 1;
        end
        POP1: begin
          m_rv = 1; m_qchk = 0;
          udf = (stk.size() == 0);
          m_q1 = (stk.size() > 0) ? stk.pop_back() : '0;
          m_q2 = '0;
        end
        POP2: begin
          m_rv = 1; m_qchk = 0;
          udf = (stk.size() == 0);
          m_q1 = (stk.size() > 0) ? stk.pop_back() : '0;
          m_q2 = (stk.size() > 0) ? stk.pop_back() : '0;
        end
        PEEK: begin
          m_rv = 1; m_qchk = 0;
          m_q1 = (stk.size() > 0) ? stk[$] : '0;
          m_q2 = (stk.size() > 1) ? stk[$-1] : '0;
        end
        CLEAR: stk.delete();
        default: begin
        end
      endcase
    end
    if (ovf) m_eo = 1;
    else if (ec) m_eo = 0;
    if (udf) m_eu = 1;
    else if (ec) m_eu = 0;
  endtask

  // One clock of stimulus; outputs are checked 1 time unit after the rising edge.
  task automatic applyStimulus(input string tag, input bit rst, input bit v,
                               input logic [CMD_W-1:0] c, input logic signed [WIDTH-1:0] dd,
                               input bit rr, input bit ec);
    @(negedge clk);
    reset = rst; cmd_valid = v; cmd = c; d = dd; rsp_ready = rr; err_clr = ec;
    #1;
    if (!rst) checkOutput({tag, ".cmd_ready"}, 64'(cmd_ready), 64'(!m_rv || rr));
    @(posedge clk);
    modelStep(rst, v, c, dd, rr, ec);
    #1;
    checkOutput({tag, ".count"}, 64'(count), 64'(stk.size()));
    checkOutput({tag, ".full"}, 64'(full), 64'(stk.size() == DEPTH));
    checkOutput({tag, ".empty"}, 64'(empty), 64'(stk.size() == 0));
    checkOutput({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(m_rv));
    if (m_rv || m_qchk) begin
      checkOutput({tag, ".q1"}, 64'(q1), 64'(m_q1));
      checkOutput({tag, ".q2"}, 64'(q2), 64'(m_q2));
    end
`ifdef OPERAND_STACK_ERR_EN
    checkOutput({tag, ".err_ovf"}, 64'(err_ovf), 64'(m_eo));
    checkOutput({tag, ".err_udf"}, 64'(err_udf), 64'(m_eu));
`endif
  endtask

  initial begin
    logic [63:0]      rnd;
    logic [CMD_W-1:0] rc;
    int               w;

    applyStimulus("rst", 1, 0, NOP, '0, 1, 0);
    applyStimulus("rst", 1, 0, NOP, '0, 1, 0);
    checkOutput("rst_empty", 64'(empty), 64'(1));
    checkOutput("rst_q1", 64'(q1), 64'(0));

    applyStimulus("p5", 0, 1, PUSH, sv(5), 1, 0);
    applyStimulus("pm3", 0, 1, PUSH, sv(-3), 1, 0);
    applyStimulus("pop2", 0, 1, POP2, '0, 1, 0);
    checkOutput("pop2_q1", 64'(q1), 64'(-3));
    checkOutput("pop2_q2", 64'(q2), 64'(5));
    checkOutput("pop2_count", 64'(count), 64'(0));

    applyStimulus("p7", 0, 1, PUSH, sv(7), 1, 0);
    applyStimulus("pop2_one", 0, 1, POP2, '0, 1, 0);
    checkOutput("pop2_one_q1", 64'(q1), 64'(7));
    checkOutput("pop2_one_q2", 64'(q2), 64'(0));
    applyStimulus("pop1_empty", 0, 1, POP1, '0, 1, 0);
    checkOutput("pop1_empty_q1", 64'(q1), 64'(0));
`ifdef OPERAND_STACK_ERR_EN
    checkOutput("pop1_empty_udf", 64'(err_udf), 64'(1));
`endif
    applyStimulus("eclr", 0, 0, NOP, '0, 1, 1);

    for (int i = 1; i <= 10; i++) applyStimulus("fill", 0, 1, PUSH, sv(i), 1, 0);
    checkOutput("fill_full", 64'(full), 64'(1));
    applyStimulus("p11", 0, 1, PUSH, sv(11), 1, 0);
    checkOutput("p11_count", 64'(count), 64'(10));
`ifdef OPERAND_STACK_ERR_EN
    checkOutput("p11_ovf", 64'(err_ovf), 64'(1));
`endif
    applyStimulus("peek", 0, 1, PEEK, '0, 1, 0);
    checkOutput("peek_q1", 64'(q1), 64'(10));
    checkOutput("peek_q2", 64'(q2), 64'(9));

    applyStimulus("clr", 0, 1, CLEAR, '0, 1, 1);
    for (int i = 1; i <= 3; i++) applyStimulus("p123", 0, 1, PUSH, sv(i), 1, 0);
    applyStimulus("hold_pop", 0, 1, POP1, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("held", 0, 1, POP1, '0, 0, 0);
      checkOutput("held_q1", 64'(q1), 64'(3));
      checkOutput("held_ready", 64'(cmd_ready), 64'(0));
    end
    applyStimulus("release", 0, 1, POP1, '0, 1, 0);
    checkOutput("release_q1", 64'(q1), 64'(2));

    applyStimulus("clr2", 0, 1, CLEAR, '0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus("p4", 0, 1, PUSH, sv(100 + i), 1, 0);
    applyStimulus("clr3", 0, 1, CLEAR, '0, 1, 0);
    checkOutput("clr3_count", 64'(count), 64'(0));
    checkOutput("clr3_empty", 64'(empty), 64'(1));
    applyStimulus("p9", 0, 1, PUSH, sv(9), 1, 0);
    applyStimulus("peek9", 0, 1, PEEK, '0, 1, 0);
    checkOutput("peek9_q1", 64'(q1), 64'(9));
    checkOutput("peek9_q2", 64'(q2), 64'(0));

    applyStimulus("pend", 0, 1, POP1, '0, 0, 0);
    applyStimulus("pend_hold", 0, 0, NOP, '0, 0, 0);
    applyStimulus("pend_rst", 1, 0, NOP, '0, 0, 0);
    checkOutput("pend_rst_valid", 64'(rsp_valid), 64'(0));
    checkOutput("pend_rst_q1", 64'(q1), 64'(0));

    for (int n = 0; n < 1500; n++) begin
      w = $urandom_range(0, 99);
      if (w < 40)      rc = PUSH;
      else if (w < 55) rc = POP1;
      else if (w < 70) rc = POP2;
      else if (w < 80) rc = PEEK;
      else if (w < 84) rc = CLEAR;
      else if (w < 90) rc = NOP;
      else             rc = 3'($urandom_range(6, 7));
      rnd = {$urandom, $urandom};
      applyStimulus("rand", $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rc,
                    rnd[WIDTH-1:0], $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
